seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Parametrised time-multiplexed driver for a common-anode bank of NDIG seven-segment digits. It converts packed 4-bit hex digits to segment patterns and scans one digit select at a time. Compared with the earlier fixed six-digit scanner, it adds tear-free frame latching, per-digit blanking and decimal points, 16-level PWM brightness and a frame-boundary pulse. It sits between the CPU's display/status registers and the board LED pins.

## Interface
- NDIG, 6, number of digits; 1..16
- DIV_W, 8, dwell per digit = 2^DIV_W cycles; minimum 4
- CLK  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock CLK
- digits  in  4*NDIG  packed hex values; digit i = digits[4i+3:4i]; digit 0 is rightmost
- dp  in  NDIG  decimal point per digit, 1 = lit
- blank  in  NDIG  per-digit blank, 1 = dark
- bright  in  4  brightness; lit for bright+1 sixteenths of each dwell
- seg  out  8  {dp,g,f,e,d,c,b,a}, 1 = segment on
- sa  out  NDIG  digit select, active-low; at most one bit low
- frame_tick  out  1  one-cycle pulse at the end of every frame

## Operation
- div counter (DIV_W bits): counts 0..2^DIV_W-1 and wraps. When div is at terminal, idx advances 0..NDIG-1 and wraps to 0.
- Shadow registers sh_digits, sh_dp, sh_blank, sh_bright:
  - Load from inputs on the cycle where idx==NDIG-1 and div is at terminal. frame_tick is asserted in that same cycle.
  - Inputs are ignored at all other times. No mid-frame change is ever displayed.
- Hex encode (a..g, bit0=a), 0-F:
  - 0-7: 3F,06,5B,4F,66,6D,7D,07
  - 8-F: 7F,6F,77,7C,39,5E,79,71
  - seg[7] = sh_dp[idx].
- Digit is lit when div[DIV_W-1:DIV_W-4] <= sh_bright and sh_blank[idx]==0 (plus any blank from the macro below).
  - When lit: sa = ~(1<<idx), seg = pattern.
  - When not lit: sa = all ones, seg = 8'h00.
- Frame length: NDIG*2^DIV_W cycles.
- Reset values:
  - div=0, idx=0, frame_tick=0.
  - seg=8'h00, sa=all ones.
  - sh_digits=0, sh_dp=0, sh_blank=all ones, sh_bright=0.
  - The display stays dark until the first frame_tick loads real data.
- Reset asserted mid-frame: all state returns to the reset values on the next edge. No partial frame output follows.

## Timing
- seg, sa and frame_tick are registered. They reflect the div/idx state of the previous cycle, giving 1 cycle of latency.
- Input change to visible output: the change is loaded at the next frame_tick, then shows 1 cycle later at the start of digit 0's dwell. Worst case is frame length + 1 cycles.
- Input changes in the same cycle as the load are captured.
- bright=15 gives full dwell. bright=0 gives 2^(DIV_W-4) lit cycles per dwell.
- sa never has two bits low in any cycle, including at idx wrap.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking on the shadow copy.
  - Starting at digit NDIG-1 and moving down, each digit with value 0 and dp=0 is blanked. The run stops at the first nonzero digit or set dp.
  - Digit 0 is never auto-blanked.
- SEG_LZB_EN undefined: zeros are displayed as 3F. Only the blank input darkens digits.

## Test plan
Bench parameters: NDIG=6, DIV_W=4 (16 cycles per digit, 96 cycles per frame).
- Hold reset for 3 cycles, then release.
  - During reset: seg=00, sa=111111, frame_tick=0.
  - Display stays dark until the first tick, which arrives at cycle 96 after release.
- digits=24'h000002, blank=0, bright=15, after one frame:
  - Digit 0 dwell: sa=111110, seg=5B for all 16 cycles.
  - Digit 1 dwell: sa=111101, seg=3F.
- Steady run: frame_tick is high exactly 1 cycle every 96 cycles. Each sa bit is low 16 consecutive cycles per frame.
- Set digits=24'h123456 mid-frame: seg is unchanged until 1 cycle after the next frame_tick. Digit 0 then shows 7D.
- bright=3, dp=6'b000010:
  - Each dwell: sa is active for 4 cycles, then all ones for 12.
  - seg[7]=1 only during digit 1.
- digits=24'h000102, blank=0:
  - With SEG_LZB_EN: digits 5-3 dark (sa=111111 during their dwells), digit 2 shows 06.
  - Without SEG_LZB_EN: digit 5 shows 3F.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner with per-frame input latching,
// blanking, decimal points and 16-level brightness. Optional `SEG_LZB_EN adds leading-zero blanking.
module seg_scan_driver #(
    parameter int NDIG  = 6,
    parameter int DIV_W = 8
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic [4*NDIG-1:0]   digits,
    input  logic [NDIG-1:0]     dp,
    input  logic [NDIG-1:0]     blank,
    input  logic [3:0]          bright,
    output logic [7:0]          seg,
    output logic [NDIG-1:0]     sa,
    output logic                frame_tick
);
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [DIV_W-1:0] DIV_TERM = '1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    logic [DIV_W-1:0]       div_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic [NDIG-1:0][3:0]   sh_digits_reg;
    logic [NDIG-1:0]        sh_dp_reg;
    logic [NDIG-1:0]        sh_blank_reg;
    logic [3:0]             sh_bright_reg;
    logic [7:0]             seg_reg, seg_next;
    logic [NDIG-1:0]        sa_reg, sa_next;
    logic                   tick_reg;

    logic                   div_term;
    logic                   frame_end;
    logic [NDIG-1:0]        select_onehot;
    logic [NDIG-1:0]        auto_blank;
    logic [3:0]             cur_digit;
    logic [6:0]             pattern;
    logic                   lit;

    assign div_term  = (div_reg == DIV_TERM);
    assign frame_end = div_term && (idx_reg == IDX_LAST);

    always_ff @(posedge CLK) begin
        if (reset) begin
            div_reg <= '0;
            idx_reg <= '0;
        end else begin
            div_reg <= div_reg + 1'b1;
            if (div_term)
                idx_reg <= frame_end ? '0 : idx_reg + 1'b1;
        end
    end

    // Inputs are sampled only at the frame boundary so a frame is never torn.
    always_ff @(posedge CLK) begin
        if (reset) begin
            sh_digits_reg <= '0;
            sh_dp_reg     <= '0;
            sh_blank_reg  <= '1;
            sh_bright_reg <= '0;
        end else if (frame_end) begin
            sh_digits_reg <= digits;
            sh_dp_reg     <= dp;
            sh_blank_reg  <= blank;
            sh_bright_reg <= bright;
        end
    end

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_select
        assign select_onehot[gi] = (idx_reg == IDX_W'(gi));
    end

`ifdef SEG_LZB_EN
    // Run of zero digits without a point, from the leftmost digit down; digit 0 always shows.
    logic [NDIG:0] lz_run;
    assign lz_run[NDIG] = 1'b1;
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_lzb
        assign lz_run[gi] = lz_run[gi+1] && (sh_digits_reg[gi] == 4'h0) && !sh_dp_reg[gi];
        if (gi == 0) begin : g_keep
            assign auto_blank[gi] = 1'b0;
        end else begin : g_run
            assign auto_blank[gi] = lz_run[gi];
        end
    end
`else
    assign auto_blank = '0;
`endif

    always_comb begin
        cur_digit = sh_digits_reg[idx_reg];
        case (cur_digit)
            4'h0: pattern = 7'h3F;
            4'h1: pattern = 7'h06;
            4'h2: pattern = 7'h5B;
            4'h3: pattern = 7'h4F;
            4'h4: pattern = 7'h66;
            4'h5: pattern = 7'h6D;
            4'h6: pattern = 7'h7D;
            4'h7: pattern = 7'h07;
            4'h8: pattern = 7'h7F;
            4'h9: pattern = 7'h6F;
            4'hA: pattern = 7'h77;
            4'hB: pattern = 7'h7C;
            4'hC: pattern = 7'h39;
            4'hD: pattern = 7'h5E;
            4'hE: pattern = 7'h79;
            default: pattern = 7'h71;
        endcase
        // Top four divider bits act as the PWM phase within the dwell.
        lit = (div_reg[DIV_W-1 -: 4] <= sh_bright_reg)
              && !sh_blank_reg[idx_reg] && !auto_blank[idx_reg];
        seg_next = 8'h00;
        sa_next  = '1;
        if (lit) begin
            seg_next = {sh_dp_reg[idx_reg], pattern};
            sa_next  = ~select_onehot;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            seg_reg  <= 8'h00;
            sa_reg   <= '1;
            tick_reg <= 1'b0;
        end else begin
            seg_reg  <= seg_next;
            sa_reg   <= sa_next;
            tick_reg <= frame_end;
        end
    end

    assign seg        = seg_reg;
    assign sa         = sa_reg;
    assign frame_tick = tick_reg;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver: frame-position reference model, directed steps and random input churn.
module tb_seg_scan_driver;
    localparam int NDIG  = 6;
    localparam int DIV_W = 4;
    localparam int DWELL = 16;
    localparam int FRAME = NDIG * DWELL;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] digits = '0;
    logic [5:0]  dp = '0;
    logic [5:0]  blank = '0;
    logic [3:0]  bright = '0;
    logic [7:0]  seg;
    logic [5:0]  sa;
    logic        frame_tick;

    seg_scan_driver #(.NDIG(NDIG), .DIV_W(DIV_W)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .digits     (digits),
        .dp         (dp),
        .blank      (blank),
        .bright     (bright),
        .seg        (seg),
        .sa         (sa),
        .frame_tick (frame_tick)
    );

    always #5 CLK = ~CLK;

    localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int passes = 0;
    int fails  = 0;
    int total  = 0;
    int n      = 0;   // clock edges since reset released = position in the frame sequence

    logic [23:0] m_digits = '0;
    logic [5:0]  m_dp = '0;
    logic [5:0]  m_blank = '1;
    logic [3:0]  m_bright = '0;
    logic [7:0]  e_seg;
    logic [5:0]  e_sa;
    logic        e_tick;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at position %0d", tag, obs, exp, n);
        end
    endtask

    // One clock: predict outputs from frame position and model shadow, then compare.
    task automatic tick_cycle();
        int s, d, ph;
        logic [5:0] eb;
        @(posedge CLK);
        if (reset) begin
            n = 0;
            m_digits = '0; m_dp = '0; m_blank = '1; m_bright = '0;
            e_seg = 8'h00; e_sa = '1; e_tick = 1'b0;
        end else begin
            s  = n % FRAME;
            d  = s / DWELL;
            ph = s % DWELL;
            eb = m_blank;
`ifdef SEG_LZB_EN
            begin
                logic run;
                run = 1'b1;
                for (int k = NDIG - 1; k >= 1; k--) begin
                    if (run && m_digits[4*k +: 4] == 4'h0 && !m_dp[k]) eb[k] = 1'b1;
                    else run = 1'b0;
                end
            end
`endif
            if (((ph >> (DIV_W - 4)) <= int'(m_bright)) && !eb[d]) begin
                e_seg = {m_dp[d], HEX[m_digits[4*d +: 4]]};
                e_sa  = ~(6'b000001 << d);
            end else begin
                e_seg = 8'h00;
                e_sa  = '1;
            end
            e_tick = (s == FRAME - 1);
            if (e_tick) begin
                m_digits = digits; m_dp = dp; m_blank = blank; m_bright = bright;
            end
            n++;
        end
        #1;
        check("seg", seg, e_seg);
        check("sa", sa, e_sa);
        check("frame_tick", frame_tick, e_tick);
        check("sa_single_low", ($countones(~sa) <= 1), 1);
    endtask

    task automatic wait_tick(input int limit, output int cnt);
        cnt = 0;
        do begin
            tick_cycle();
            cnt++;
        end while (frame_tick !== 1'b1 && cnt < limit);
        total++;
        assert (frame_tick === 1'b1) passes++;
        else begin
            fails++;
            $error("FAIL tick_timeout: observed no frame_tick within %0d cycles expected one", limit);
        end
    endtask

    initial begin
        int cnt;
        reset = 1'b1;
        repeat (3) tick_cycle();
        check("rst_seg", seg, 8'h00);
        check("rst_sa", sa, 6'b111111);

        digits = 24'h000002; dp = '0; blank = '0; bright = 4'd15;
        reset  = 1'b0;
        wait_tick(200, cnt);
        check("first_tick_latency", cnt, 96);
        tick_cycle();
        check("d0_seg", seg, 8'h5B);
        check("d0_sa", sa, 6'b111110);
        repeat (15) tick_cycle();
        tick_cycle();
        check("d1_seg", seg, 8'h3F);
        check("d1_sa", sa, 6'b111101);

        repeat (40) tick_cycle();
        digits = 24'h123456;
        wait_tick(200, cnt);
        tick_cycle();
        check("new_d0_seg", seg, 8'h7D);
        check("new_d0_sa", sa, 6'b111110);

        bright = 4'd3; dp = 6'b000010;
        wait_tick(200, cnt);
        wait_tick(200, cnt);
        check("tick_period", cnt, 96);
        tick_cycle();
        check("dim_ph0_sa", sa, 6'b111110);
        repeat (3) tick_cycle();
        tick_cycle();
        check("dim_ph4_sa", sa, 6'b111111);
        repeat (11) tick_cycle();
        tick_cycle();
        check("dp_d1_seg", seg, 8'hED);
        check("dp_d1_sa", sa, 6'b111101);

        digits = 24'h000102; dp = '0; blank = '0; bright = 4'd15;
        wait_tick(200, cnt);
        wait_tick(200, cnt);
        repeat (80) tick_cycle();
        tick_cycle();
`ifdef SEG_LZB_EN
        check("d5_lzb_sa", sa, 6'b111111);
        check("d5_lzb_seg", seg, 8'h00);
`else
        check("d5_zero_sa", sa, 6'b011111);
        check("d5_zero_seg", seg, 8'h3F);
`endif
        repeat (15) tick_cycle();

        for (int i = 0; i < 10 * FRAME; i++) begin
            if ($urandom_range(15) == 0) begin
                case ($urandom_range(3))
                    0: digits = 24'($urandom);
                    1: dp     = 6'($urandom);
                    2: blank  = ($urandom_range(3) == 0) ? 6'($urandom) : 6'b0;
                    default: bright = 4'($urandom);
                endcase
            end
            tick_cycle();
        end

        repeat (37) tick_cycle();
        reset = 1'b1;
        tick_cycle();
        check("midrst_seg", seg, 8'h00);
        check("midrst_sa", sa, 6'b111111);
        check("midrst_tick", frame_tick, 1'b0);
        reset = 1'b0;
        repeat (2 * FRAME) tick_cycle();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
